// File: rtl/cordic_arbiter.sv
// cordic_arbiter: round-robin shares one cordic between N_REQ requesters and routes
// each sin/cos result back to its issuer in strict issue order.
module cordic_arbiter #(
    parameter int N_REQ        = 4,
    parameter int BITS         = 16,
    parameter int THETA_W      = 32,
    parameter int MAX_INFLIGHT = 16
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [N_REQ-1:0]                    req_valid,
    input  logic [N_REQ*THETA_W-1:0]            req_theta,
    output logic [N_REQ-1:0]                    req_ready,
    output logic [N_REQ-1:0]                    rsp_valid,
    output logic [BITS-1:0]                     rsp_sin,
    output logic [BITS-1:0]                     rsp_cos,
    input  logic [N_REQ-1:0]                    rsp_ready,
    output logic                                theta_wr_en,
    output logic [31:0]                         theta_din,
    input  logic                                theta_full,
    output logic                                sin_rd_en,
    input  logic [BITS-1:0]                     sin_dout,
    input  logic                                sin_empty,
    output logic                                cos_rd_en,
    input  logic [BITS-1:0]                     cos_dout,
    input  logic                                cos_empty,
    output logic [$clog2(MAX_INFLIGHT):0]       inflight,
    output logic                                err_orphan
);
    localparam int IW = $clog2(N_REQ);
    localparam int TW = $clog2(MAX_INFLIGHT);
    localparam int CW = TW + 1;

    typedef enum logic [1:0] {R_IDLE, R_READ, R_HOLD} state_t;

    state_t              r_state, w_next;
    logic [IW-1:0]       r_rr_ptr;
    logic [IW-1:0]       r_tag_mem [MAX_INFLIGHT];
    logic [TW-1:0]       r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]       r_tcount, r_inflight;
    logic [IW-1:0]       r_cur_tag;
    logic [N_REQ-1:0]    r_rsp_valid;
    logic [BITS-1:0]     r_rsp_sin, r_rsp_cos;
    logic                r_err_orphan;

    logic                w_can_issue, w_grant_any, w_grant;
    logic [IW-1:0]       w_grant_idx;
    logic [THETA_W-1:0]  w_theta;
    logic                w_fifo_rdy, w_tag_ne, w_rd, w_hs, w_tag_pop;

    // Highest k assigned first so the nearest requester after rr_ptr wins.
    always_comb begin
        w_grant_any = 1'b0;
        w_grant_idx = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_valid[(int'(r_rr_ptr) + k) % N_REQ]) begin
                w_grant_any = 1'b1;
                w_grant_idx = IW'((int'(r_rr_ptr) + k) % N_REQ);
            end
        end
    end

    assign w_can_issue = reset && !theta_full && (r_inflight < CW'(MAX_INFLIGHT));
    assign w_grant     = w_can_issue && w_grant_any;
    assign w_theta     = req_theta[w_grant_idx*THETA_W +: THETA_W];
    assign req_ready   = w_grant ? (N_REQ'(1) << w_grant_idx) : '0;
    assign theta_wr_en = w_grant;
    assign theta_din   = w_grant ? 32'(w_theta) : '0;

    assign w_fifo_rdy = !sin_empty && !cos_empty;
    assign w_tag_ne   = r_tcount != '0;
    assign w_hs       = (r_state == R_HOLD) && rsp_ready[r_cur_tag];
    assign w_tag_pop  = r_state == R_READ;

    always_ff @(posedge clk) begin
        if (!reset)
            r_state <= R_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            R_IDLE:  w_next = (w_fifo_rdy && w_tag_ne) ? R_READ : R_IDLE;
            R_READ:  w_next = R_HOLD;
            R_HOLD:  w_next = w_hs ? R_IDLE : R_HOLD;
            default: w_next = R_IDLE;
        endcase
    end

    always_comb begin
        w_rd = reset && (r_state == R_IDLE) && w_fifo_rdy && w_tag_ne;
    end

    assign sin_rd_en = w_rd;
    assign cos_rd_en = w_rd;

    always_ff @(posedge clk) begin
        if (w_grant)
            r_tag_mem[r_wr_ptr] <= w_grant_idx;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rr_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_tcount   <= '0;
            r_inflight <= '0;
        end else begin
            if (w_grant) begin
                r_rr_ptr <= (w_grant_idx == IW'(N_REQ - 1)) ? '0 : w_grant_idx + 1'b1;
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_tag_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            r_tcount   <= r_tcount + CW'(w_grant) - CW'(w_tag_pop);
            r_inflight <= r_inflight + CW'(w_grant) - CW'(w_hs);
        end
    end

    // Results with no queued tag cannot be routed; flag them and leave the FIFOs alone.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cur_tag    <= '0;
            r_rsp_valid  <= '0;
            r_rsp_sin    <= '0;
            r_rsp_cos    <= '0;
            r_err_orphan <= 1'b0;
        end else begin
            if (r_state == R_READ) begin
                r_rsp_sin   <= sin_dout;
                r_rsp_cos   <= cos_dout;
                r_cur_tag   <= r_tag_mem[r_rd_ptr];
                r_rsp_valid <= N_REQ'(1) << r_tag_mem[r_rd_ptr];
            end else if (w_hs) begin
                r_rsp_valid <= '0;
            end
            if ((r_state == R_IDLE) && w_fifo_rdy && !w_tag_ne)
                r_err_orphan <= 1'b1;
        end
    end

    assign rsp_valid  = r_rsp_valid;
    assign rsp_sin    = r_rsp_sin;
    assign rsp_cos    = r_rsp_cos;
    assign inflight   = r_inflight;
    assign err_orphan = r_err_orphan;
endmodule

// File: tb/tb_cordic_arbiter.sv
// tb_cordic_arbiter: directed bench with a behavioural cordic FIFO model around the arbiter.
module tb_cordic_arbiter;
    localparam int N = 4;

    logic           clk, reset;
    logic [N-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
    logic [N*32-1:0] req_theta;
    logic [15:0]    rsp_sin, rsp_cos, sin_dout, cos_dout;
    logic           theta_wr_en, theta_full, sin_rd_en, sin_empty, cos_rd_en, cos_empty;
    logic [31:0]    theta_din;
    logic [4:0]     inflight;
    logic           err_orphan;
    logic           force_ne;

    int checks = 0;
    int errors = 0;

    logic [31:0] mq [64];
    logic [5:0]  mwp, mrp;
    logic [15:0] m_sin, m_cos;

    logic [15:0] rr_sin [5] = '{16'd0, 16'd8192, 16'd14189, 16'd16384, 16'd0};
    logic [15:0] rr_cos [5] = '{16'd16384, 16'd14189, 16'd8192, 16'd0, 16'd16384};

    cordic_arbiter dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_theta(req_theta), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_sin(rsp_sin), .rsp_cos(rsp_cos), .rsp_ready(rsp_ready),
        .theta_wr_en(theta_wr_en), .theta_din(theta_din), .theta_full(theta_full),
        .sin_rd_en(sin_rd_en), .sin_dout(sin_dout), .sin_empty(sin_empty),
        .cos_rd_en(cos_rd_en), .cos_dout(cos_dout), .cos_empty(cos_empty),
        .inflight(inflight), .err_orphan(err_orphan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference angles map to hand-computed Q2.14 values; any other angle gets a tagged pattern.
    function automatic logic [31:0] cordic_model(input logic [31:0] th);
        case (th)
            32'd0:     return {16'd0, 16'd16384};
            32'd8579:  return {16'd8192, 16'd14189};
            32'd17157: return {16'd14189, 16'd8192};
            32'd25736: return {16'd16384, 16'd0};
            default:   return {th[15:0], ~th[15:0]};
        endcase
    endfunction

    always @(posedge clk) begin
        if (!reset) begin
            mwp <= '0;
            mrp <= '0;
        end else begin
            if (theta_wr_en && !theta_full) begin
                mq[mwp] <= cordic_model(theta_din);
                mwp <= mwp + 1'b1;
            end
            if (sin_rd_en && mwp != mrp) begin
                {m_sin, m_cos} <= mq[mrp];
                mrp <= mrp + 1'b1;
            end
        end
    end

    assign sin_empty = force_ne ? 1'b0 : (mwp == mrp);
    assign cos_empty = force_ne ? 1'b0 : (mwp == mrp);
    assign sin_dout  = m_sin;
    assign cos_dout  = m_cos;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_rsp(input int bound);
        int t = 0;
        while (rsp_valid == '0 && t < bound) begin
            tick();
            t++;
        end
        chk("rsp_arrives", 64'(rsp_valid != '0), 64'd1);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        theta_full = 1'b0;
        force_ne = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        int grants, rcv;
        logic [15:0] e;
        req_theta = '0;
        do_reset();
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_inflight", 64'(inflight), 64'd0);
        chk("rst_orphan", 64'(err_orphan), 64'd0);
        chk("rst_rd_en", 64'({sin_rd_en, cos_rd_en, theta_wr_en}), 64'd0);
        reset = 1'b1;

        // single 90 degree request
        req_valid = 4'b0001;
        req_theta[0 +: 32] = 32'd25736;
        #1;
        chk("single_ready", 64'(req_ready), 64'b0001);
        chk("single_wr_en", 64'(theta_wr_en), 64'd1);
        chk("single_din", 64'(theta_din), 64'd25736);
        chk("single_inflight0", 64'(inflight), 64'd0);
        tick();
        req_valid = '0;
        #1;
        chk("single_inflight1", 64'(inflight), 64'd1);
        chk("single_no_regrant", 64'(theta_wr_en), 64'd0);
        wait_rsp(20);
        chk("single_rsp_valid", 64'(rsp_valid), 64'b0001);
        chk("single_sin", 64'(rsp_sin), 64'd16384);
        chk("single_cos", 64'(rsp_cos), 64'd0);
        rsp_ready = 4'b1111;
        tick();
        chk("single_rsp_clear", 64'(rsp_valid), 64'd0);
        chk("single_inflight_end", 64'(inflight), 64'd0);

        // round robin with all requesters active
        do_reset();
        reset = 1'b1;
        req_theta = {32'd25736, 32'd17157, 32'd8579, 32'd0};
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("rr_grant", 64'(req_ready), 64'(4'b0001 << (k % 4)));
            chk("rr_din", 64'(theta_din), 64'(req_theta[(k % 4)*32 +: 32]));
            tick();
        end
        req_valid = '0;
        #1;
        chk("rr_inflight", 64'(inflight), 64'd5);
        rsp_ready = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_rsp(20);
            chk("rr_rsp_valid", 64'(rsp_valid), 64'(4'b0001 << (k % 4)));
            chk("rr_rsp_data", 64'({rsp_sin, rsp_cos}), 64'({rr_sin[k], rr_cos[k]}));
            tick();
        end
        chk("rr_inflight_end", 64'(inflight), 64'd0);

        // theta FIFO backpressure
        do_reset();
        reset = 1'b1;
        theta_full = 1'b1;
        req_valid = 4'b0100;
        req_theta[2*32 +: 32] = 32'h1234;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("bp_no_grant", 64'({req_ready, theta_wr_en}), 64'd0);
            chk("bp_din_zero", 64'(theta_din), 64'd0);
            tick();
        end
        theta_full = 1'b0;
        #1;
        chk("bp_grant", 64'(req_ready), 64'b0100);
        chk("bp_din", 64'(theta_din), 64'h1234);
        tick();
        req_valid = '0;

        // inflight throttle then in-order drain
        do_reset();
        reset = 1'b1;
        grants = 0;
        for (int c = 0; c < 20; c++) begin
            req_valid = 4'b0001;
            req_theta[0 +: 32] = 32'(100 + grants);
            #1;
            if (req_ready[0]) grants++;
            tick();
        end
        #1;
        chk("thr_grants", 64'(grants), 64'd16);
        chk("thr_inflight", 64'(inflight), 64'd16);
        chk("thr_no_ready", 64'(req_ready), 64'd0);
        rsp_ready = 4'b0001;
        rcv = 0;
        for (int t = 0; t < 300 && rcv < 20; t++) begin
            req_valid = (grants < 20) ? 4'b0001 : 4'b0000;
            req_theta[0 +: 32] = 32'(100 + grants);
            #1;
            if (rsp_valid != '0) begin
                e = 16'(100 + rcv);
                chk("thr_drain", 64'({rsp_valid, rsp_sin, rsp_cos}), 64'({4'b0001, e, ~e}));
                rcv++;
            end
            if (req_ready[0]) grants++;
            tick();
        end
        req_valid = '0;
        chk("thr_total_grants", 64'(grants), 64'd20);
        chk("thr_total_rcv", 64'(rcv), 64'd20);
        chk("thr_inflight_end", 64'(inflight), 64'd0);

        // response stall then reset mid-operation
        do_reset();
        reset = 1'b1;
        req_valid = 4'b0010;
        req_theta[1*32 +: 32] = 32'h55;
        req_theta[3*32 +: 32] = 32'h77;
        tick();
        req_valid = 4'b1000;
        tick();
        req_valid = '0;
        wait_rsp(20);
        for (int c = 0; c < 10; c++) begin
            chk("stall_data", 64'({rsp_valid, rsp_sin, rsp_cos}), 64'({4'b0010, 16'h55, ~16'h55}));
            chk("stall_no_read", 64'(sin_rd_en), 64'd0);
            chk("stall_inflight", 64'(inflight), 64'd2);
            tick();
        end
        reset = 1'b0;
        req_valid = 4'b1111;
        req_theta[0 +: 32] = 32'd7;
        tick();
        tick();
        chk("mid_rst_ready", 64'({req_ready, theta_wr_en}), 64'd0);
        chk("mid_rst_rsp", 64'({rsp_valid, rsp_sin, rsp_cos}), 64'd0);
        chk("mid_rst_rd", 64'({sin_rd_en, cos_rd_en}), 64'd0);
        chk("mid_rst_inflight", 64'(inflight), 64'd0);
        reset = 1'b1;
        #1;
        chk("mid_rst_regrant", 64'(req_ready), 64'b0001);
        chk("mid_rst_din", 64'(theta_din), 64'd7);
        tick();
        req_valid = '0;

        // orphan result
        do_reset();
        reset = 1'b1;
        for (int c = 0; c < 20 && inflight != '0; c++) tick();
        force_ne = 1'b1;
        #1;
        chk("orph_pre", 64'({err_orphan, sin_rd_en}), 64'd0);
        tick();
        chk("orph_set", 64'(err_orphan), 64'd1);
        chk("orph_no_read", 64'({sin_rd_en, cos_rd_en}), 64'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("orph_sticky", 64'({err_orphan, sin_rd_en}), 64'b10);
        end
        force_ne = 1'b0;
        tick();
        chk("orph_sticky_after", 64'(err_orphan), 64'd1);
        do_reset();
        chk("orph_cleared", 64'(err_orphan), 64'd0);
        reset = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
